dark_clkrst_gen: RTL and testbench

//   Clock/reset front end for darkdpgroup, sitting between board pins and core group.

---
 rtl/dark_clk_pkg.sv | 13 +
 rtl/dark_rst_sync.sv | 20 ++
 rtl/dark_clkrst_gen.sv | 135 +++++++++++++
 tb/tb_dark_clkrst_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dark_clk_pkg.sv
// Shared defaults and reset-release state encoding for the darksoc clock/reset front end.
package dark_clk_pkg;

  localparam int DIV_W_DFLT   = 19;
  localparam int DIV_RST_DFLT = 262144;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } rel_state_e;

endpackage

// File: rtl/dark_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clock edge.
module dark_rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign rst_n_sync = sync[1];

endmodule

// File: rtl/dark_clkrst_gen.sv
// XCLK divider with glitch-free divisor reload and a core reset released on a clk_out falling edge.
// Optional heartbeat output is built only when CLKGEN_HEARTBEAT_EN is defined.
module dark_clkrst_gen
  import dark_clk_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DFLT,
  parameter int DIV_RST  = DIV_RST_DFLT,
  parameter int HOLD_N   = 16,
  parameter int HB_SHIFT = 4
) (
  input  logic             XCLK,
  input  logic             XRES,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick,
  output logic             rst_n_out,
  output logic             locked,
  output logic             hb
);

  localparam int HOLD_W = (HOLD_N > 0) ? $clog2(HOLD_N + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_N);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  half;
  logic [DIV_W-1:0]  pend;
  logic [DIV_W-1:0]  half_eff;
  logic              term;
  logic              rise;
  logic              fall;
  logic              xres_sync;
  rel_state_e        state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              rst_n_nxt;

  assign half_eff = (half == '0) ? DIV_W'(1) : half;
  assign term     = (cnt == half_eff - DIV_W'(1));
  assign rise     = term & ~clk_out;
  assign fall     = term &  clk_out;

  // A new divisor only lands on a terminal, so it governs whole half-periods.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      cnt      <= '0;
      half     <= DIV_RST_V;
      pend     <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_busy <= 1'b0;
    end else begin
      tick <= term;
      if (term) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        if (div_busy) half <= pend;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (div_wr) begin
        pend     <= div_val;
        div_busy <= 1'b1;
      end else if (term) begin
        div_busy <= 1'b0;
      end
    end
  end

  dark_rst_sync u_rst_sync (
    .clk        (XCLK),
    .rst_n      (XRES),
    .rst_n_sync (xres_sync)
  );

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state     <= IDLE;
      hold      <= '0;
      rst_n_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      rst_n_out <= rst_n_nxt;
    end
  end

  // Count core-clock rising edges, then release on the next falling edge.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    rst_n_nxt = rst_n_out;
    case (state)
      IDLE: begin
        if (xres_sync) state_nxt = HOLD;
      end
      HOLD: begin
        if (rise && hold != HOLD_MAX) hold_nxt = hold + HOLD_W'(1);
        if (fall && hold == HOLD_MAX) begin
          state_nxt = RUN;
          rst_n_nxt = 1'b1;
        end
      end
      RUN: begin
        rst_n_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign locked = rst_n_out;

`ifdef CLKGEN_HEARTBEAT_EN
  logic [HB_SHIFT:0] hb_cnt;

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      hb_cnt <= '0;
    end else if (!rst_n_out) begin
      hb_cnt <= '0;
    end else if (rise) begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign hb = hb_cnt[HB_SHIFT];
`else
  // Constant 0; HB_SHIFT only shapes the heartbeat build.
  assign hb = (HB_SHIFT < 0);
`endif

endmodule

// File: tb/tb_dark_clkrst_gen.sv
// Bench for dark_clkrst_gen: cycle model in terms of remaining half-period and edge counts.
module tb_dark_clkrst_gen;

  localparam int DIV_W    = 8;
  localparam int DIV_RST  = 4;
  localparam int HOLD_N   = 2;
  localparam int HB_SHIFT = 2;
  // Two synchroniser flops plus the step out of IDLE before edges are counted.
  localparam int SYNC_LAT = 3;

  logic             XCLK = 1'b0;
  logic             XRES;
  logic             div_wr;
  logic [DIV_W-1:0] div_val;
  logic             div_busy, clk_out, tick, rst_n_out, locked, hb;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  dark_clkrst_gen #(
    .DIV_W    (DIV_W),
    .DIV_RST  (DIV_RST),
    .HOLD_N   (HOLD_N),
    .HB_SHIFT (HB_SHIFT)
  ) dut (
    .XCLK      (XCLK),
    .XRES      (XRES),
    .div_wr    (div_wr),
    .div_val   (div_val),
    .div_busy  (div_busy),
    .clk_out   (clk_out),
    .tick      (tick),
    .rst_n_out (rst_n_out),
    .locked    (locked),
    .hb        (hb)
  );

  always #5 XCLK = ~XCLK;

  // Model state: cycles left in the current half-period, and edge counts.
  int m_rem = DIV_RST, m_half = DIV_RST, m_pend = 0, m_rises = 0, m_age = 0, m_hbrises = 0;
  bit m_busy = 0, m_clk = 0, m_tick = 0, m_rstn = 0;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge XCLK or negedge XRES) begin
    bit term, rise, fall, armed;
    if (!XRES) begin
      m_rem = DIV_RST; m_half = DIV_RST; m_pend = 0; m_busy = 0;
      m_clk = 0; m_tick = 0; m_rstn = 0; m_rises = 0; m_age = 0; m_hbrises = 0;
    end else begin
      term  = (m_rem == 1);
      rise  = term && !m_clk;
      fall  = term && m_clk;
      armed = (m_age >= SYNC_LAT);
      if (m_age < SYNC_LAT) m_age++;
      if (m_rstn && rise) m_hbrises++;
      if (armed && !m_rstn) begin
        if (fall && m_rises == HOLD_N) m_rstn = 1;
        if (rise && m_rises < HOLD_N) m_rises++;
      end
      m_tick = term;
      if (term) begin
        if (m_busy) m_half = eff(m_pend);
        m_clk = !m_clk;
        m_rem = m_half;
      end else begin
        m_rem--;
      end
      if (div_wr) begin
        m_pend = int'(div_val);
        m_busy = 1;
      end else if (term) begin
        m_busy = 0;
      end
    end
  end

  function automatic bit m_hb();
`ifdef CLKGEN_HEARTBEAT_EN
    return bit'((m_hbrises >> HB_SHIFT) & 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cmp(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge XCLK) begin
    if (chk_en) begin
      cmp("clk_out",   clk_out,   m_clk);
      cmp("tick",      tick,      m_tick);
      cmp("rst_n_out", rst_n_out, m_rstn);
      cmp("locked",    locked,    m_rstn);
      cmp("div_busy",  div_busy,  m_busy);
      cmp("hb",        hb,        m_hb());
    end
  end

  task automatic step();
    @(posedge XCLK);
    #2;
  endtask

  task automatic do_wr(input int v);
    div_wr  = 1'b1;
    div_val = DIV_W'(v);
    step();
    div_wr  = 1'b0;
  endtask

  task automatic wait_tick(output int g);
    g = 0;
    do begin
      step();
      g++;
    end while (!tick && g < 200);
    if (!tick) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_tick timeout at %0t", $time);
    end
  endtask

  task automatic wait_release(output int n, output int nt);
    n  = 0;
    nt = 0;
    while (!rst_n_out && n < 200) begin
      step();
      n++;
      if (tick) nt++;
    end
  endtask

  int   g, n, nt;
  logic prev;

  initial begin
    XRES    = 1'b1;
    div_wr  = 1'b0;
    div_val = '0;
    #1 XRES = 1'b0;
    #2 chk_en = 1'b1;

    repeat (3) step();
    lit("rst_clk_out", clk_out, 0);
    lit("rst_tick", tick, 0);
    lit("rst_rst_n_out", rst_n_out, 0);
    lit("rst_div_busy", div_busy, 0);

    XRES = 1'b1;
    wait_release(n, nt);
    lit("release_edges", n, 16);
    lit("release_ticks", nt, 4);
    lit("release_on_fall", clk_out, 0);
    wait_tick(g);
    lit("half_after_rst", g, 4);

    // 4 -> 2 written mid half-period
    step();
    do_wr(2);
    lit("busy_after_wr", div_busy, 1);
    wait_tick(g);
    lit("old_half_completes", g, 2);
    lit("busy_cleared", div_busy, 0);
    wait_tick(g);
    lit("new_half_1", g, 2);
    wait_tick(g);
    lit("new_half_2", g, 2);

    // go to 5, then write 3 and 6 before a terminal
    do_wr(5);
    wait_tick(g);
    lit("apply5_gap", g, 1);
    wait_tick(g);
    lit("half5", g, 5);
    do_wr(3);
    do_wr(6);
    wait_tick(g);
    lit("half5_completes", g, 3);
    wait_tick(g);
    lit("last_write_wins_1", g, 6);
    wait_tick(g);
    lit("last_write_wins_2", g, 6);

    // write landing on a terminal edge: becomes pending for the next one
    repeat (5) step();
    do_wr(4);
    lit("wr_on_term_tick", tick, 1);
    lit("wr_on_term_busy", div_busy, 1);
    wait_tick(g);
    lit("wr_on_term_keep6", g, 6);
    wait_tick(g);
    lit("wr_on_term_then4", g, 4);

    // divisor 0 behaves as 1
    do_wr(0);
    wait_tick(g);
    lit("div0_last_half", g, 3);
    for (int i = 0; i < 6; i++) begin
      prev = clk_out;
      step();
      lit("div0_tick", tick, 1);
      lit("div0_toggle", clk_out, int'(!prev));
    end
    lit("run_unaffected", rst_n_out, 1);

    // async reset mid half-period with clk_out high
    do_wr(3);
    n = 0;
    do begin
      step();
      n++;
    end while (!(clk_out && !tick && !div_busy && n > 3) && n < 40);
    lit("pre_reset_clk_high", clk_out, 1);
    XRES = 1'b0;
    #1;
    lit("async_clk_out", clk_out, 0);
    lit("async_rst_n_out", rst_n_out, 0);
    lit("async_busy", div_busy, 0);
    lit("async_tick", tick, 0);
    repeat (3) step();
    XRES = 1'b1;
    wait_release(n, nt);
    lit("rerelease_edges", n, 16);
    wait_tick(g);
    lit("rerelease_half", g, 4);

    repeat (20) step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
